can_xrtl_dispatch: RTL

//  Synthesizable N-node packet dispatcher between the SCE-MI pipes and the CAN node array.
//  TX: hands each requesting node a distinct packet from the input stream (round-robin), drives node TX/RX IDs.
//  RX: captures per-node received packets, serialises them through a FIFO to the output stream.

---
 rtl/can_xrtl_dispatch.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/can_xrtl_dispatch.sv
// can_xrtl_dispatch: N-node CAN packet dispatcher between the SCE-MI pipes and the node array.
// TX side hands each requesting node its own packet from the input stream (round-robin) and
// drives per-node TX/RX IDs; RX side parks per-node received packets and drains them one per
// cycle through a FIFO to the output stream, counting packets overwritten before drain.
// Optional build macro CAN_DISPATCH_STATS_EN adds tx_grant_count / rx_out_count.

// Per-node RX holding slot: one pending packet, overwritten (and flagged) if not drained in time.
module can_xrtl_dispatch_node #(
  parameter int DATA_SIZE = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cap,
  input  logic                 drain,
  input  logic [DATA_SIZE-1:0] rx_data,
  output logic                 pend,
  output logic [DATA_SIZE-1:0] pend_data,
  output logic                 ovw
);
  logic                 pend_q, pend_d;
  logic [DATA_SIZE-1:0] pend_data_q, pend_data_d;

  // capture re-arms the slot even when it is being drained; capture onto an undrained slot is a loss
  always_comb begin
    pend_d      = cap | (pend_q & ~drain);
    pend_data_d = cap ? rx_data : pend_data_q;
    ovw         = cap & pend_q & ~drain;
  end

  // slot registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_q      <= 1'b0;
      pend_data_q <= '0;
    end else begin
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
    end
  end

  assign pend      = pend_q;
  assign pend_data = pend_data_q;
endmodule

module can_xrtl_dispatch #(
  parameter int NODES      = 4,
  parameter int DATA_SIZE  = 64,
  parameter int ID_SIZE    = 11,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         id_load,
  input  logic [NODES*ID_SIZE-1:0]     id_value,
  input  logic                         pkt_valid,
  input  logic [DATA_SIZE-1:0]         pkt_data,
  output logic                         pkt_ready,
  input  logic [NODES-1:0]             data_in_req,
  input  logic [NODES-1:0]             retransmit,
  output logic [NODES*DATA_SIZE-1:0]   in_packet,
  output logic [NODES*ID_SIZE-1:0]     tx_id,
  output logic [NODES*ID_SIZE-1:0]     rx_id,
  input  logic [NODES-1:0]             data_out_req,
  input  logic [NODES*DATA_SIZE-1:0]   rx_packet,
  output logic                         out_valid,
  output logic [DATA_SIZE-1:0]         out_data,
  output logic [$clog2(NODES)-1:0]     out_node,
  input  logic                         out_ready,
  output logic [15:0]                  lost_count
`ifdef CAN_DISPATCH_STATS_EN
  ,
  output logic [31:0]                  tx_grant_count,
  output logic [31:0]                  rx_out_count
`endif
);
  localparam int NW = $clog2(NODES);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = NW + DATA_SIZE;

  typedef enum logic {ID_WAIT, RUN} state_t;
  state_t state_q, state_d;

  logic [NODES-1:0][ID_SIZE-1:0]    id_q, id_d, tx_id_q, tx_id_d, rx_id_q, rx_id_d;
  logic [NODES-1:0][DATA_SIZE-1:0]  in_packet_q, in_packet_d, rx_pk, pend_data;
  logic [NW-1:0]                    tx_ptr_q, tx_ptr_d, rx_ptr_q, rx_ptr_d, gidx, didx;
  logic [FIFO_DEPTH-1:0][EW-1:0]    mem_q, mem_d;
  logic [AW-1:0]                    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]                      count_q, count_d;
  logic [15:0]                      lost_q, lost_d;
  logic [16:0]                      lost_sum;
  logic [NODES-1:0]                 elig, pend, drain, ovw;
  logic                             grant, dfound, pop;

  assign rx_pk = rx_packet;

  // ID table load; first load leaves ID_WAIT, later loads just refresh the table
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    if (id_load) begin
      id_d    = id_value;
      state_d = RUN;
    end
  end

  // TX arbiter: first eligible node at/after tx_ptr, only when a packet is on offer
  always_comb begin
    logic [NW-1:0] idx;
    elig  = data_in_req & ~retransmit;
    grant = 1'b0;
    gidx  = '0;
    idx   = '0;
    for (int k = 0; k < NODES; k++) begin
      idx = NW'((int'(tx_ptr_q) + k) % NODES);
      if (!grant && elig[idx]) begin
        grant = 1'b1;
        gidx  = idx;
      end
    end
    grant = grant & pkt_valid & (state_q == RUN);
  end

  assign pkt_ready = grant;

  // TX outputs: granted node takes the packet and its ID; pure retransmitters drop their ID;
  // partner RX IDs follow the previous cycle's TX IDs
  always_comb begin
    in_packet_d = in_packet_q;
    tx_id_d     = tx_id_q;
    tx_ptr_d    = tx_ptr_q;
    rx_id_d     = rx_id_q;
    for (int i = 0; i < NODES; i++)
      if (retransmit[i] && !data_in_req[i]) tx_id_d[i] = '0;
    if (grant) begin
      in_packet_d[gidx] = pkt_data;
      tx_id_d[gidx]     = id_q[gidx];
      tx_ptr_d          = NW'((int'(gidx) + 1) % NODES);
    end
    for (int k = 0; k < NODES / 2; k++) begin
      rx_id_d[2*k]   = tx_id_q[2*k+1];
      rx_id_d[2*k+1] = tx_id_q[2*k];
    end
  end

  for (genvar i = 0; i < NODES; i++) begin : g_node
    can_xrtl_dispatch_node #(.DATA_SIZE(DATA_SIZE)) u_node (
      .clock     (clock),
      .reset     (reset),
      .cap       (data_out_req[i]),
      .drain     (drain[i]),
      .rx_data   (rx_pk[i]),
      .pend      (pend[i]),
      .pend_data (pend_data[i]),
      .ovw       (ovw[i])
    );
  end

  // RX drain: one pending node per cycle, round-robin; a pop in the same cycle never frees room
  always_comb begin
    logic [NW-1:0] idx;
    drain    = '0;
    didx     = '0;
    dfound   = 1'b0;
    rx_ptr_d = rx_ptr_q;
    idx      = '0;
    if (count_q < (AW+1)'(FIFO_DEPTH)) begin
      for (int k = 0; k < NODES; k++) begin
        idx = NW'((int'(rx_ptr_q) + k) % NODES);
        if (!dfound && pend[idx]) begin
          dfound = 1'b1;
          didx   = idx;
        end
      end
    end
    if (dfound) begin
      drain[didx] = 1'b1;
      rx_ptr_d    = NW'((int'(didx) + 1) % NODES);
    end
  end

  assign pop       = out_valid & out_ready;
  assign out_valid = (count_q != '0);
  assign {out_node, out_data} = mem_q[rd_ptr_q];

  // output FIFO bookkeeping and saturating loss counter
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (dfound) begin
      mem_d[wr_ptr_q] = {didx, pend_data[didx]};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d  = count_q + (AW+1)'(dfound) - (AW+1)'(pop);
    lost_sum = {1'b0, lost_q} + 17'($countones(ovw));
    lost_d   = lost_sum[16] ? 16'hFFFF : lost_sum[15:0];
  end

  // state registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ID_WAIT;  id_q <= '0;  tx_ptr_q <= '0;  rx_ptr_q <= '0;
      in_packet_q <= '0;  tx_id_q <= '0;  rx_id_q <= '0;
      mem_q <= '0;  wr_ptr_q <= '0;  rd_ptr_q <= '0;  count_q <= '0;  lost_q <= '0;
    end else begin
      state_q <= state_d;  id_q <= id_d;  tx_ptr_q <= tx_ptr_d;  rx_ptr_q <= rx_ptr_d;
      in_packet_q <= in_packet_d;  tx_id_q <= tx_id_d;  rx_id_q <= rx_id_d;
      mem_q <= mem_d;  wr_ptr_q <= wr_ptr_d;  rd_ptr_q <= rd_ptr_d;  count_q <= count_d;
      lost_q <= lost_d;
    end
  end

  assign in_packet  = in_packet_q;
  assign tx_id      = tx_id_q;
  assign rx_id      = rx_id_q;
  assign lost_count = lost_q;

`ifdef CAN_DISPATCH_STATS_EN
  logic [31:0] tx_grant_q, tx_grant_d, rx_out_q, rx_out_d;

  // wrap-around activity counters
  always_comb begin
    tx_grant_d = tx_grant_q + 32'(grant);
    rx_out_d   = rx_out_q + 32'(pop);
  end

  // counter registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_grant_q <= '0;
      rx_out_q   <= '0;
    end else begin
      tx_grant_q <= tx_grant_d;
      rx_out_q   <= rx_out_d;
    end
  end

  assign tx_grant_count = tx_grant_q;
  assign rx_out_count   = rx_out_q;
`endif
endmodule
